// File: rtl/lcd_ctrl.sv
// HD44780-compatible character LCD write controller.
// Runs the power-up wait and the init ROM, then sends one byte per handshake with setup/pulse/hold/exec timing.
module lcd_ctrl #(
    parameter int unsigned T_POWERUP   = 750000,
    parameter int unsigned T_SETUP     = 2,
    parameter int unsigned T_PULSE     = 12,
    parameter int unsigned T_HOLD      = 2,
    parameter int unsigned T_EXEC      = 1850,
    parameter int unsigned T_EXEC_LONG = 76000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    input  logic       i_on,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_init_done,
    output logic       o_lcd_on,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
);

    // A zero timing parameter still costs one cycle.
    localparam int unsigned PW_C   = (T_POWERUP   == 0) ? 1 : T_POWERUP;
    localparam int unsigned SU_C   = (T_SETUP     == 0) ? 1 : T_SETUP;
    localparam int unsigned PU_C   = (T_PULSE     == 0) ? 1 : T_PULSE;
    localparam int unsigned HO_C   = (T_HOLD      == 0) ? 1 : T_HOLD;
    localparam int unsigned EX_C   = (T_EXEC      == 0) ? 1 : T_EXEC;
    localparam int unsigned EL_C   = (T_EXEC_LONG == 0) ? 1 : T_EXEC_LONG;

    localparam int unsigned MAX_A  = (PW_C > SU_C) ? PW_C : SU_C;
    localparam int unsigned MAX_B  = (PU_C > HO_C) ? PU_C : HO_C;
    localparam int unsigned MAX_E  = (EX_C > EL_C) ? EX_C : EL_C;
    localparam int unsigned MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_C  = (MAX_AB > MAX_E) ? MAX_AB : MAX_E;
    localparam int unsigned CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t PW_END = cnt_t'(PW_C - 1);
    localparam cnt_t SU_END = cnt_t'(SU_C - 1);
    localparam cnt_t PU_END = cnt_t'(PU_C - 1);
    localparam cnt_t HO_END = cnt_t'(HO_C - 1);
    localparam cnt_t EX_END = cnt_t'(EX_C - 1);
    localparam cnt_t EL_END = cnt_t'(EL_C - 1);

    typedef enum logic [2:0] {
        PWRUP,
        INIT,
        SETUP,
        PULSE,
        HOLD,
        WAIT,
        IDLE
    } state_t;

    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic       en_q, en_d;
    logic       rs_q, rs_d;
    logic [7:0] data_q, data_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       on_q;

    logic       longCmd;
    cnt_t       waitEnd;

    function automatic logic [7:0] initRom(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h38;
            3'd1:    b = 8'h38;
            3'd2:    b = 8'h0C;
            3'd3:    b = 8'h01;
            default: b = 8'h06;
        endcase
        return b;
    endfunction

    // Clear and return-home need the long execution time.
    assign longCmd = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);
    assign waitEnd = longCmd ? EL_END : EX_END;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + cnt_t'(1);
        idx_d   = idx_q;
        en_d    = en_q;
        rs_d    = rs_q;
        data_d  = data_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = done_q;

        unique case (state_q)
            PWRUP: begin
                if (cnt_q >= PW_END) begin
                    state_d = INIT;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    rs_d    = 1'b0;
                    data_d  = initRom(3'd0);
                end
            end
            // The ROM byte is loaded on entry, so this cycle is the first setup cycle.
            INIT: begin
                state_d = SETUP;
                cnt_d   = cnt_t'(1);
            end
            SETUP: begin
                if (cnt_q >= SU_END) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q >= PU_END) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    en_d    = 1'b0;
                end
            end
            HOLD: begin
                if (cnt_q >= HO_END) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (cnt_q >= waitEnd) begin
                    cnt_d = '0;
                    if (!done_q && (idx_q < 3'd4)) begin
                        state_d = INIT;
                        idx_d   = idx_q + 3'd1;
                        rs_d    = 1'b0;
                        data_d  = initRom(idx_q + 3'd1);
                    end else begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (i_valid) begin
                    state_d = SETUP;
                    rs_d    = i_rs;
                    data_d  = i_data;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = PWRUP;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset abandons any transfer and restarts the power-up wait.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= PWRUP;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            on_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            on_q    <= i_on;
        end
    end

    assign o_ready     = ready_q;
    assign o_busy      = busy_q;
    assign o_init_done = done_q;
    assign o_lcd_on    = on_q;
    assign o_lcd_en    = en_q;
    assign o_lcd_rs    = rs_q;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_data  = data_q;

endmodule
